// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: default widths, opcodes,
// condition-flag bit positions and the execute-stage state encoding.
package cpu_pkg;

    localparam int CPU_DATA_W = 8;
    localparam int CPU_ADDR_W = 4;
    localparam int CPU_OP_W   = 4;

    localparam logic [CPU_OP_W-1:0] OP_NOP = 4'd0;
    localparam logic [CPU_OP_W-1:0] OP_ADD = 4'd1;
    localparam logic [CPU_OP_W-1:0] OP_SUB = 4'd2;
    localparam logic [CPU_OP_W-1:0] OP_AND = 4'd3;
    localparam logic [CPU_OP_W-1:0] OP_OR  = 4'd4;
    localparam logic [CPU_OP_W-1:0] OP_XOR = 4'd5;
    localparam logic [CPU_OP_W-1:0] OP_SHL = 4'd6;
    localparam logic [CPU_OP_W-1:0] OP_SHR = 4'd7;
    localparam logic [CPU_OP_W-1:0] OP_MUL = 4'd8;
    localparam logic [CPU_OP_W-1:0] OP_MOV = 4'd9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per edge for W edges after start;
// done and the full product are presented combinationally on the last step.
module seq_multiplier
    import cpu_pkg::*;
#(
    parameter int W = CPU_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic               active_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*W-1:0]     acc_r;
    logic [2*W-1:0]     mcand_r;
    logic [W-1:0]       mplier_r;
    logic [2*W-1:0]     acc_next_s;

    // Partial-product accumulation for the current multiplier bit
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign done    = active_r && (cnt_r == CNT_W'(W - 1));
    assign product = acc_next_s;

    // Iteration state: load on start, then shift one bit per edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
        end else if (start) begin
            active_r <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
        end else if (active_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[2*W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[W-1:1]};
            if (done) begin
                active_r <= 1'b0;
                cnt_r    <= {CNT_W{1'b0}};
            end else begin
                cnt_r    <= cnt_r + 1'b1;
            end
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU plus multi-cycle multiply, register-bank
// write-back port and Z/C/N condition flags.
module exec_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int OP_W   = CPU_OP_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [ADDR_W-1:0] i_destadd,
    input  logic [DATA_W-1:0] i_read_data1,
    input  logic [DATA_W-1:0] i_read_data2,
    output logic              o_busy,
    output logic              o_write_en,
    output logic [ADDR_W-1:0] o_write_reg,
    output logic [DATA_W-1:0] o_write_data,
    output logic              o_flag_z,
    output logic              o_flag_c,
    output logic              o_flag_n
);

    function automatic logic [FLAG_W-1:0] flags_of(input logic [DATA_W-1:0] res, input logic c);
        logic [FLAG_W-1:0] f;
        f         = {FLAG_W{1'b0}};
        f[FLAG_Z] = (res == {DATA_W{1'b0}});
        f[FLAG_C] = c;
        f[FLAG_N] = res[DATA_W-1];
        return f;
    endfunction

    exec_state_e         state_r, state_next_s;
    logic [ADDR_W-1:0]   dest_r, dest_s;
    logic                write_en_r, write_en_s;
    logic [ADDR_W-1:0]   write_reg_r, write_reg_s;
    logic [DATA_W-1:0]   write_data_r, write_data_s;
    logic [FLAG_W-1:0]   flags_r, flags_s;

    logic [DATA_W-1:0]   alu_res_s;
    logic                alu_c_s;
    logic                alu_single_s;
    logic [DATA_W:0]     sum_s;
    logic                mul_start_s;
    logic                mul_done_s;
    logic [2*DATA_W-1:0] mul_product_s;
    logic [DATA_W-1:0]   mul_res_s;
    logic                mul_c_s;

    seq_multiplier #(.W(DATA_W)) u_mul (
        .clk     (i_clk),
        .rst_n   (i_reset),
        .start   (mul_start_s),
        .a       (i_read_data1),
        .b       (i_read_data2),
        .done    (mul_done_s),
        .product (mul_product_s)
    );

    assign mul_res_s = mul_product_s[DATA_W-1:0];
    assign mul_c_s   = |mul_product_s[2*DATA_W-1:DATA_W];
    assign sum_s     = {1'b0, i_read_data1} + {1'b0, i_read_data2};

    // Single-cycle ALU datapath
    always_comb begin
        alu_res_s    = {DATA_W{1'b0}};
        alu_c_s      = 1'b0;
        alu_single_s = 1'b1;
        case (i_opcode)
            OP_ADD: begin
                alu_res_s = sum_s[DATA_W-1:0];
                alu_c_s   = sum_s[DATA_W];
            end
            OP_SUB: begin
                alu_res_s = i_read_data1 - i_read_data2;
                alu_c_s   = (i_read_data1 < i_read_data2);
            end
            OP_AND: alu_res_s = i_read_data1 & i_read_data2;
            OP_OR:  alu_res_s = i_read_data1 | i_read_data2;
            OP_XOR: alu_res_s = i_read_data1 ^ i_read_data2;
            OP_SHL: begin
                alu_res_s = {i_read_data1[DATA_W-2:0], 1'b0};
                alu_c_s   = i_read_data1[DATA_W-1];
            end
            OP_SHR: begin
                alu_res_s = {1'b0, i_read_data1[DATA_W-1:1]};
                alu_c_s   = i_read_data1[0];
            end
            OP_MOV: alu_res_s = i_read_data1;
            default: alu_single_s = 1'b0;
        endcase
    end

    // Next-state and next-output logic; valid is only honoured in IDLE
    always_comb begin
        state_next_s = state_r;
        mul_start_s  = 1'b0;
        dest_s       = dest_r;
        write_en_s   = 1'b0;
        write_reg_s  = write_reg_r;
        write_data_s = write_data_r;
        flags_s      = flags_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid && alu_single_s) begin
                    write_en_s = (i_destadd != {ADDR_W{1'b0}});
                    flags_s    = flags_of(alu_res_s, alu_c_s);
                    if (write_en_s) begin
                        write_reg_s  = i_destadd;
                        write_data_s = alu_res_s;
                    end else begin
                        write_reg_s  = write_reg_r;
                        write_data_s = write_data_r;
                    end
                end else if (i_valid && (i_opcode == OP_MUL)) begin
                    state_next_s = ST_MUL;
                    mul_start_s  = 1'b1;
                    dest_s       = i_destadd;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_next_s = ST_IDLE;
                    write_en_s   = (dest_r != {ADDR_W{1'b0}});
                    flags_s      = flags_of(mul_res_s, mul_c_s);
                    if (write_en_s) begin
                        write_reg_s  = dest_r;
                        write_data_s = mul_res_s;
                    end else begin
                        write_reg_s  = write_reg_r;
                        write_data_s = write_data_r;
                    end
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered write-back port, latched destination and flags
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            dest_r       <= {ADDR_W{1'b0}};
            write_en_r   <= 1'b0;
            write_reg_r  <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
            flags_r      <= {FLAG_W{1'b0}};
        end else begin
            dest_r       <= dest_s;
            write_en_r   <= write_en_s;
            write_reg_r  <= write_reg_s;
            write_data_r <= write_data_s;
            flags_r      <= flags_s;
        end
    end

    assign o_busy       = (state_r == ST_MUL);
    assign o_write_en   = write_en_r;
    assign o_write_reg  = write_reg_r;
    assign o_write_data = write_data_r;
    assign o_flag_z     = flags_r[FLAG_Z];
    assign o_flag_c     = flags_r[FLAG_C];
    assign o_flag_n     = flags_r[FLAG_N];

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios followed by random
// operations compared against an arithmetic reference model.
module tb_exec_stage;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic [3:0] destadd = 4'd0;
    logic [7:0] rd1 = 8'd0;
    logic [7:0] rd2 = 8'd0;
    logic       busy, write_en, fz, fc, fn;
    logic [3:0] write_reg;
    logic [7:0] write_data;

    int checks = 0;
    int errors = 0;
    int ez = 0, ec = 0, en = 0;

    exec_stage dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_valid      (valid),
        .i_opcode     (opcode),
        .i_destadd    (destadd),
        .i_read_data1 (rd1),
        .i_read_data2 (rd2),
        .o_busy       (busy),
        .o_write_en   (write_en),
        .o_write_reg  (write_reg),
        .o_write_data (write_data),
        .o_flag_z     (fz),
        .o_flag_c     (fc),
        .o_flag_n     (fn)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 = no effect, 1 = single-cycle, 2 = multiply
    function automatic void ref_op(input int op, input int a, input int b,
                                   output int kind, output int res, output int c);
        int full;
        kind = 1;
        c    = 0;
        full = 0;
        case (op)
            1: full = a + b;
            2: begin full = (a - b + 256); c = (a < b) ? 1 : 0; end
            3: full = a & b;
            4: full = a | b;
            5: full = a ^ b;
            6: full = a * 2;
            7: begin full = a / 2; c = a % 2; end
            8: begin full = a * b; kind = 2; end
            9: full = a;
            default: kind = 0;
        endcase
        res = full % 256;
        if (op == 1 || op == 6 || op == 8) c = (full > 255) ? 1 : 0;
    endfunction

    task automatic check_flags(input string tag);
        check_val({tag, ".z"}, fz, ez);
        check_val({tag, ".c"}, fc, ec);
        check_val({tag, ".n"}, fn, en);
    endtask

    // Issue one operation for a single cycle; for MUL optionally drive an
    // ADD during busy cycle inject_at (1..7) that must be ignored.
    task automatic issue(input int op, input int a, input int b, input int dest, input int inject_at);
        int kind, res, c;
        ref_op(op, a, b, kind, res, c);
        opcode  = op[3:0];
        rd1     = a[7:0];
        rd2     = b[7:0];
        destadd = dest[3:0];
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        if (kind == 2) begin
            for (int k = 1; k <= 8; k++) begin
                check_val("mul.busy", busy, 1);
                check_val("mul.no_early_we", write_en, 0);
                if (k == inject_at) begin
                    valid   = 1'b1;
                    opcode  = 4'd1;
                    rd1     = 8'($urandom);
                    rd2     = 8'($urandom);
                    destadd = 4'($urandom_range(1, 15));
                end else begin
                    valid = 1'b0;
                end
                @(negedge clk);
            end
            valid = 1'b0;
        end
        if (kind != 0) begin
            ez = (res == 0) ? 1 : 0;
            ec = c;
            en = (res >= 128) ? 1 : 0;
        end
        check_val("busy_after", busy, 0);
        check_val("write_en", write_en, ((kind != 0) && (dest != 0)) ? 1 : 0);
        if ((kind != 0) && (dest != 0)) begin
            check_val("write_reg", write_reg, dest);
            check_val("write_data", write_data, res);
        end
        check_flags("flags");
    endtask

    task automatic reset_mid_mul();
        opcode  = 4'd8;
        rd1     = 8'hB7;
        rd2     = 8'h5D;
        destadd = 4'd6;
        valid   = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check_val("rst.busy", busy, 1);
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        ez = 0; ec = 0; en = 0;
        check_val("rst.busy0", busy, 0);
        check_val("rst.we0", write_en, 0);
        check_val("rst.reg0", write_reg, 0);
        check_val("rst.data0", write_data, 0);
        check_flags("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_val("rst.no_write", write_en, 0);
            check_val("rst.idle", busy, 0);
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_val("reset.busy", busy, 0);
        check_val("reset.we", write_en, 0);
        check_val("reset.reg", write_reg, 0);
        check_val("reset.data", write_data, 0);
        check_flags("reset");
        reset = 1'b1;

        issue(1, 'h7F, 'h01, 3, 0);
        issue(2, 'h05, 'h05, 2, 0);
        issue(2, 'h03, 'h05, 2, 0);
        issue(8, 'h0F, 'h11, 7, 0);
        issue(8, 'h20, 'h10, 7, 0);
        issue(1, 'hFF, 'h01, 0, 0);
        issue(15, 'h12, 'h34, 5, 0);
        issue(8, 'h0C, 'h0B, 5, 3);
        issue(6, 'h81, 'h00, 1, 0);
        issue(7, 'h03, 'h00, 4, 0);
        reset_mid_mul();

        for (int i = 0; i < 200; i++) begin
            int op, inj;
            op  = (i % 5 == 0) ? 8 : int'($urandom_range(0, 15));
            inj = int'($urandom_range(0, 7));
            issue(op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)), inj);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
